ddr3_avl_responder: RTL and testbench

Synthesizable stand-in for `ddr3_controller` on the Avalon-MM side: it answers the `avl_*` burst protocol that test and system masters issue, backed by on-chip block RAM instead of DDR3. It emulates init/calibration status and read latency, so masters such as `test` can run in simulation, or on boards without DDR3, with no change. It sits where `ddr3_controller` sits and exposes the same `avl_*` and `local_*` ports. It does not expose the `mem_*` pins.

---
 rtl/ddr3_avl_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_ddr3_avl_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_avl_responder.sv
// Block-RAM backed stand-in for the DDR3 controller's Avalon-MM side.
// Emulates init/calibration status, burst writes with byte enables, and fixed-latency burst reads.
module ddr3_avl_responder #(
    parameter int DATA_BITS      = 64,
    parameter int ADDR_BITS      = 24,
    parameter int MEM_DEPTH_BITS = 10,
    parameter int READ_LATENCY   = 4,
    parameter int INIT_CYCLES    = 16,
    parameter int FORCE_CAL_FAIL = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   avl_ready,
    input  logic                   avl_burstbegin,
    input  logic [ADDR_BITS-1:0]   avl_addr,
    input  logic [6:0]             avl_size,
    input  logic                   avl_write_req,
    input  logic [DATA_BITS-1:0]   avl_wdata,
    input  logic [DATA_BITS/8-1:0] avl_be,
    input  logic                   avl_read_req,
    output logic                   avl_rdata_valid,
    output logic [DATA_BITS-1:0]   avl_rdata,
    output logic                   local_init_done,
    output logic                   local_cal_success,
    output logic                   local_cal_fail,
    output logic                   protocol_error
);
    localparam int NBYTES = DATA_BITS / 8;
    localparam int DEPTH  = 1 << MEM_DEPTH_BITS;
    localparam int PIPE   = READ_LATENCY - 2;
    localparam int CNT_W  = $clog2(INIT_CYCLES + 1) + 1;

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_READ, ST_CAL_FAILED} state_t;

    state_t                    state_reg, state_next;
    logic [CNT_W-1:0]          init_cnt_reg, init_cnt_next;
    logic [MEM_DEPTH_BITS-1:0] base_reg, base_next;
    logic [7:0]                len_reg, len_next;
    logic [7:0]                beat_reg, beat_next;
    logic [7:0]                dlv_reg, dlv_next;
    logic                      init_done_reg, init_done_next;
    logic                      cal_ok_reg, cal_ok_next;
    logic                      cal_fail_reg, cal_fail_next;
    logic                      perr_reg, perr_next;

    logic                      mem_we, mem_re;
    logic [MEM_DEPTH_BITS-1:0] mem_waddr, mem_raddr;
    logic [DATA_BITS-1:0]      ram_q;
    logic                      ram_v_reg;
    logic [DATA_BITS-1:0]      tail_d;
    logic                      tail_v;
    logic                      rvalid_reg;
    logic [DATA_BITS-1:0]      rdata_reg;

    logic                      wr_acc, rd_acc;
    logic [7:0]                req_len, beat_inc, dlv_inc;
    logic [MEM_DEPTH_BITS-1:0] req_base;
    logic                      unused_addr_bits;

    assign avl_ready         = (state_reg == ST_IDLE) || (state_reg == ST_WRITE);
    assign wr_acc            = avl_ready && avl_write_req;
    assign rd_acc            = avl_ready && avl_read_req && !avl_write_req;
    assign req_len           = (avl_size == 7'd0) ? 8'd1 : {1'b0, avl_size};
    assign req_base          = avl_addr[MEM_DEPTH_BITS-1:0];
    assign beat_inc          = beat_reg + 8'd1;
    assign dlv_inc           = dlv_reg + 8'd1;
    assign unused_addr_bits  = ^avl_addr[ADDR_BITS-1:MEM_DEPTH_BITS];

    assign avl_rdata_valid   = rvalid_reg;
    assign avl_rdata         = rdata_reg;
    assign local_init_done   = init_done_reg;
    assign local_cal_success = cal_ok_reg;
    assign local_cal_fail    = cal_fail_reg;
    assign protocol_error    = perr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_INIT;
            init_cnt_reg  <= '0;
            base_reg      <= '0;
            len_reg       <= 8'd1;
            beat_reg      <= '0;
            dlv_reg       <= '0;
            init_done_reg <= 1'b0;
            cal_ok_reg    <= 1'b0;
            cal_fail_reg  <= 1'b0;
            perr_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            init_cnt_reg  <= init_cnt_next;
            base_reg      <= base_next;
            len_reg       <= len_next;
            beat_reg      <= beat_next;
            dlv_reg       <= dlv_next;
            init_done_reg <= init_done_next;
            cal_ok_reg    <= cal_ok_next;
            cal_fail_reg  <= cal_fail_next;
            perr_reg      <= perr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        init_cnt_next  = init_cnt_reg;
        base_next      = base_reg;
        len_next       = len_reg;
        beat_next      = beat_reg;
        dlv_next       = dlv_reg;
        init_done_next = init_done_reg;
        cal_ok_next    = cal_ok_reg;
        cal_fail_next  = cal_fail_reg;
        perr_next      = perr_reg;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        mem_waddr      = '0;
        mem_raddr      = '0;
        case (state_reg)
            ST_INIT: begin
                if (init_cnt_reg == CNT_W'(INIT_CYCLES)) begin
                    init_done_next = 1'b1;
                    if (FORCE_CAL_FAIL != 0) begin
                        cal_fail_next = 1'b1;
                        state_next    = ST_CAL_FAILED;
                    end else begin
                        cal_ok_next = 1'b1;
                        state_next  = ST_IDLE;
                    end
                end else begin
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
            end
            ST_IDLE, ST_WRITE: begin
                if (wr_acc) begin
                    mem_we = 1'b1;
                    if (avl_read_req) perr_next = 1'b1;
                    // A beat in IDLE or any burstbegin starts a fresh burst at the presented address.
                    if (state_reg == ST_IDLE || avl_burstbegin) begin
                        if (!avl_burstbegin || avl_size == 7'd0 || state_reg == ST_WRITE)
                            perr_next = 1'b1;
                        base_next  = req_base;
                        len_next   = req_len;
                        mem_waddr  = req_base;
                        beat_next  = 8'd1;
                        state_next = (req_len == 8'd1) ? ST_IDLE : ST_WRITE;
                    end else begin
                        mem_waddr  = base_reg + MEM_DEPTH_BITS'(beat_reg);
                        beat_next  = beat_inc;
                        state_next = (beat_inc == len_reg) ? ST_IDLE : ST_WRITE;
                    end
                end else if (rd_acc) begin
                    if (avl_size == 7'd0 || state_reg == ST_WRITE) perr_next = 1'b1;
                    base_next  = req_base;
                    len_next   = req_len;
                    beat_next  = 8'd1;
                    dlv_next   = 8'd0;
                    mem_re     = 1'b1;
                    mem_raddr  = req_base;
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (beat_reg < len_reg) begin
                    mem_re    = 1'b1;
                    mem_raddr = base_reg + MEM_DEPTH_BITS'(beat_reg);
                    beat_next = beat_inc;
                end
                // Ready reopens in the cycle after the last beat is presented.
                if (rvalid_reg) begin
                    dlv_next = dlv_inc;
                    if (dlv_inc == len_reg) state_next = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    // One narrow RAM per byte lane so byte enables map onto plain write enables.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;
            always_ff @(posedge clk) begin
                if (mem_we && avl_be[gi]) mem[mem_waddr] <= avl_wdata[gi*8 +: 8];
                if (mem_re) q_reg <= mem[mem_raddr];
            end
            assign ram_q[gi*8 +: 8] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) ram_v_reg <= 1'b0;
        else       ram_v_reg <= mem_re;
    end

    generate
        if (PIPE == 0) begin : g_nopipe
            assign tail_d = ram_q;
            assign tail_v = ram_v_reg;
        end else begin : g_pipe
            logic [DATA_BITS-1:0] d_reg [PIPE];
            logic [PIPE-1:0]      v_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_reg <= '0;
                end else begin
                    v_reg[0] <= ram_v_reg;
                    for (int i = 1; i < PIPE; i++) v_reg[i] <= v_reg[i-1];
                end
            end
            always_ff @(posedge clk) begin
                d_reg[0] <= ram_q;
                for (int i = 1; i < PIPE; i++) d_reg[i] <= d_reg[i-1];
            end
            assign tail_d = d_reg[PIPE-1];
            assign tail_v = v_reg[PIPE-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= tail_v;
            if (tail_v) rdata_reg <= tail_d;
        end
    end
endmodule

// File: tb/tb_ddr3_avl_responder.sv
// Directed bench for ddr3_avl_responder: init, calibration failure, bursts, byte enables, wrap, errors, reset.
module tb_ddr3_avl_responder;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        avl_burstbegin = 1'b0;
    logic [23:0] avl_addr = '0;
    logic [6:0]  avl_size = '0;
    logic        avl_write_req = 1'b0;
    logic [63:0] avl_wdata = '0;
    logic [7:0]  avl_be = '0;
    logic        avl_read_req = 1'b0;

    logic        avl_ready, avl_rdata_valid, local_init_done, local_cal_success, local_cal_fail, protocol_error;
    logic [63:0] avl_rdata;
    logic        f_ready, f_rvalid, f_init_done, f_cal_ok, f_cal_fail, f_perr;
    logic [63:0] f_rdata;

    int checks = 0;
    int errors = 0;
    logic [63:0] wq [8];
    logic [63:0] rq [8];

    always #5 clk = ~clk;

    ddr3_avl_responder dut (
        .clk(clk), .reset(reset), .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin),
        .avl_addr(avl_addr), .avl_size(avl_size), .avl_write_req(avl_write_req),
        .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_read_req(avl_read_req),
        .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
        .local_init_done(local_init_done), .local_cal_success(local_cal_success),
        .local_cal_fail(local_cal_fail), .protocol_error(protocol_error)
    );

    ddr3_avl_responder #(.FORCE_CAL_FAIL(1)) dut_fail (
        .clk(clk), .reset(reset), .avl_ready(f_ready), .avl_burstbegin(avl_burstbegin),
        .avl_addr(avl_addr), .avl_size(avl_size), .avl_write_req(avl_write_req),
        .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_read_req(avl_read_req),
        .avl_rdata_valid(f_rvalid), .avl_rdata(f_rdata),
        .local_init_done(f_init_done), .local_cal_success(f_cal_ok),
        .local_cal_fail(f_cal_fail), .protocol_error(f_perr)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic idle_inputs();
        avl_burstbegin = 1'b0;
        avl_write_req  = 1'b0;
        avl_read_req   = 1'b0;
        avl_be         = 8'h00;
    endtask

    task automatic write_burst(input logic [23:0] a, input int n, input logic [7:0] b);
        for (int k = 0; k < n; k++) begin
            avl_burstbegin = (k == 0);
            avl_addr       = a;
            avl_size       = 7'(n);
            avl_write_req  = 1'b1;
            avl_wdata      = wq[k];
            avl_be         = b;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        $display("write addr=0x%0h beats=%0d be=0x%0h", a, n, b);
    endtask

    // Observation j is taken 1 time unit after edge T+j, where T is the accept edge.
    task automatic read_burst(input logic [23:0] a, input int n, input string tag);
        logic        v [16];
        logic        r [16];
        logic [63:0] d [16];
        int          first;
        int          nvalid;
        avl_burstbegin = 1'b1;
        avl_addr       = a;
        avl_size       = 7'(n);
        avl_read_req   = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        for (int j = 1; j <= L + n + 1; j++) begin
            @(posedge clk);
            #1;
            v[j] = avl_rdata_valid;
            r[j] = avl_ready;
            d[j] = avl_rdata;
        end
        first  = 0;
        nvalid = 0;
        for (int j = L + n + 1; j >= 1; j--) if (v[j]) first = j;
        for (int j = 1; j <= L + n + 1; j++) if (v[j]) nvalid++;
        $display("read addr=0x%0h beats=%0d first_valid_obs=%0d", a, n, first);
        check_val({tag, "_first_valid"}, 64'(first), 64'(L - 1));
        check_val({tag, "_valid_count"}, 64'(nvalid), 64'(n));
        check_val({tag, "_ready_busy"}, 64'(r[1]), 64'd0);
        for (int k = 0; k < n; k++) begin
            check_val($sformatf("%s_beat%0d_valid", tag, k), 64'(v[L - 1 + k]), 64'd1);
            check_val($sformatf("%s_beat%0d_data", tag, k), d[L - 1 + k], rq[k]);
        end
        check_val({tag, "_ready_last_beat"}, 64'(r[L + n - 2]), 64'd0);
        check_val({tag, "_ready_back"}, 64'(r[L + n - 1]), 64'd1);
    endtask

    task automatic wait_init(input string tag);
        int   n;
        logic early;
        n     = 0;
        early = 1'b0;
        while (!local_init_done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!local_init_done) early = early | avl_ready;
        end
        check_val({tag, "_init_edges"}, 64'(n), 64'd17);
        check_val({tag, "_ready_low_in_init"}, 64'(early), 64'd0);
        check_val({tag, "_ready_after_init"}, 64'(avl_ready), 64'd1);
        check_val({tag, "_cal_success"}, 64'(local_cal_success), 64'd1);
        check_val({tag, "_cal_fail"}, 64'(local_cal_fail), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   n;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", 64'(avl_ready), 64'd0);
        check_val("rst_rvalid", 64'(avl_rdata_valid), 64'd0);
        check_val("rst_rdata", avl_rdata, 64'd0);
        check_val("rst_init_done", 64'(local_init_done), 64'd0);
        check_val("rst_cal_success", 64'(local_cal_success), 64'd0);
        check_val("rst_cal_fail", 64'(local_cal_fail), 64'd0);
        check_val("rst_perr", 64'(protocol_error), 64'd0);
        reset = 1'b0;
        wait_init("init");

        check_val("calfail_init_done", 64'(f_init_done), 64'd1);
        check_val("calfail_fail_flag", 64'(f_cal_fail), 64'd1);
        check_val("calfail_success_flag", 64'(f_cal_ok), 64'd0);
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            seen = seen | f_ready | f_rvalid;
        end
        check_val("calfail_ready_stays_low", 64'(seen), 64'd0);
        check_val("calfail_perr", 64'(f_perr), 64'd0);
        check_val("calfail_rdata", f_rdata, 64'd0);

        wq[0] = 64'h1111_1111_1111_1111;
        wq[1] = 64'h2222_2222_2222_2222;
        wq[2] = 64'h3333_3333_3333_3333;
        wq[3] = 64'h4444_4444_4444_4444;
        write_burst(24'h10, 4, 8'hFF);
        for (int k = 0; k < 4; k++) rq[k] = wq[k];
        read_burst(24'h10, 4, "burst4");
        check_val("clean_perr", 64'(protocol_error), 64'd0);

        wq[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        write_burst(24'h5, 1, 8'hFF);
        wq[0] = 64'h0;
        write_burst(24'h5, 1, 8'h0F);
        rq[0] = 64'hFFFF_FFFF_0000_0000;
        read_burst(24'h5, 1, "byte_en");

        wq[0] = 64'hA;
        wq[1] = 64'hB;
        write_burst(24'h3FF, 2, 8'hFF);
        rq[0] = 64'hB;
        read_burst(24'h000, 1, "wrap");
        read_burst(24'h400, 1, "alias");
        rq[0] = 64'hA;
        rq[1] = 64'hB;
        read_burst(24'h3FF, 2, "read_wrap");
        check_val("wrap_perr", 64'(protocol_error), 64'd0);

        avl_burstbegin = 1'b1;
        avl_addr       = 24'h20;
        avl_size       = 7'd1;
        avl_write_req  = 1'b1;
        avl_read_req   = 1'b1;
        avl_wdata      = 64'h5A;
        avl_be         = 8'hFF;
        @(posedge clk);
        #1;
        idle_inputs();
        $display("simultaneous read+write addr=0x20");
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen = seen | avl_rdata_valid;
        end
        check_val("simul_no_read_data", 64'(seen), 64'd0);
        check_val("simul_perr", 64'(protocol_error), 64'd1);
        check_val("simul_ready", 64'(avl_ready), 64'd1);
        rq[0] = 64'h5A;
        read_burst(24'h20, 1, "simul_write");

        avl_burstbegin = 1'b1;
        avl_addr       = 24'h10;
        avl_size       = 7'd4;
        avl_read_req   = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        n = 0;
        while (!avl_rdata_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("midrst_saw_beat", 64'(avl_rdata_valid), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        $display("reset asserted mid-read");
        check_val("midrst_rvalid", 64'(avl_rdata_valid), 64'd0);
        check_val("midrst_perr", 64'(protocol_error), 64'd0);
        check_val("midrst_ready", 64'(avl_ready), 64'd0);
        check_val("midrst_init_done", 64'(local_init_done), 64'd0);
        reset = 1'b0;
        wait_init("reinit");
        for (int k = 0; k < 4; k++) rq[k] = wq[k];
        rq[0] = 64'h1111_1111_1111_1111;
        rq[1] = 64'h2222_2222_2222_2222;
        rq[2] = 64'h3333_3333_3333_3333;
        rq[3] = 64'h4444_4444_4444_4444;
        read_burst(24'h10, 4, "ram_kept");

        wq[0] = 64'h77;
        write_burst(24'h30, 0, 8'hFF);
        check_val("size0_perr_before", 64'(protocol_error), 64'd0);
        avl_burstbegin = 1'b1;
        avl_addr       = 24'h30;
        avl_size       = 7'd0;
        avl_write_req  = 1'b1;
        avl_wdata      = 64'h77;
        avl_be         = 8'hFF;
        @(posedge clk);
        #1;
        idle_inputs();
        $display("write addr=0x30 size=0");
        check_val("size0_perr", 64'(protocol_error), 64'd1);
        check_val("size0_ready", 64'(avl_ready), 64'd1);
        rq[0] = 64'h77;
        read_burst(24'h30, 1, "size0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
